// File: rtl/axil_reg_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
// Holds response codes, FSM state enums and the byte-strobe merge.
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                r[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage: strobe-merged writes, read mux, flat output vector.
// Optional per-register write pulse under AXIL_REG_SLAVE_WR_PULSE_EN.
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_strb,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [31:0]            rd_data,
    output logic [NUM_REGS*32-1:0] reg_out
`ifdef AXIL_REG_SLAVE_WR_PULSE_EN
    , output logic [NUM_REGS-1:0]  wr_pulse
`endif
);

    logic [31:0] regs [NUM_REGS];

    // Storage update; only the addressed register is touched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= apply_wstrb(regs[wr_idx], wr_data, wr_strb);
        end
    end

    // Read mux sees the pre-write value during a commit cycle.
    assign rd_data = regs[rd_idx];

    // Flatten the array so register k sits at bits [32k+31:32k].
    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_out[32*k +: 32] = regs[k];
        end
    end

`ifdef AXIL_REG_SLAVE_WR_PULSE_EN
    // One-cycle pulse after each in-range commit, strobes irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_en) begin
                wr_pulse[wr_idx] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave with independent write and read FSMs.
// Define AXIL_REG_SLAVE_WR_PULSE_EN to add the wr_pulse output.
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
    input  logic [2:0]             S_AXI_AWPROT,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]  S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic [2:0]             S_AXI_ARPROT,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]  S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0] reg_out
`ifdef AXIL_REG_SLAVE_WR_PULSE_EN
    , output logic [NUM_REGS-1:0]  wr_pulse
`endif
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int LO_W  = $clog2(NUM_REGS * 4);

    wr_state_t        wr_state;
    rd_state_t        rd_state;
    logic [IDX_W-1:0] aw_idx;
    logic             aw_oor;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             aw_oor_c;
    logic             ar_oor_c;
    logic             bank_we;
    logic [31:0]      bank_rd;
    logic             unused_bits;

    assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
    assign aw_oor_c = (S_AXI_AWADDR >> LO_W) != '0;
    assign ar_oor_c = (S_AXI_ARADDR >> LO_W) != '0;
    assign bank_we  = (wr_state == W_COMMIT) && !aw_oor;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk      (S_AXI_ACLK),
        .rst      (S_AXI_ARESET),
        .wr_en    (bank_we),
        .wr_idx   (aw_idx),
        .wr_data  (w_data),
        .wr_strb  (w_strb),
        .rd_idx   (S_AXI_ARADDR[IDX_W+1:2]),
        .rd_data  (bank_rd),
        .reg_out  (reg_out)
`ifdef AXIL_REG_SLAVE_WR_PULSE_EN
        , .wr_pulse (wr_pulse)
`endif
    );

    // Write FSM: collect AW and W in any order, commit, then respond.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state      <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_idx        <= '0;
            aw_oor        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
        end else begin
            if (aw_hs) begin
                aw_idx <= S_AXI_AWADDR[IDX_W+1:2];
                aw_oor <= aw_oor_c;
            end
            if (w_hs) begin
                w_data <= S_AXI_WDATA[31:0];
                w_strb <= S_AXI_WSTRB;
            end
            unique case (wr_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state      <= W_COMMIT;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                    end else if (aw_hs) begin
                        wr_state      <= W_HAVE_AW;
                        S_AXI_AWREADY <= 1'b0;
                    end else if (w_hs) begin
                        wr_state      <= W_HAVE_W;
                        S_AXI_WREADY  <= 1'b0;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        wr_state     <= W_COMMIT;
                        S_AXI_WREADY <= 1'b0;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        wr_state      <= W_COMMIT;
                        S_AXI_AWREADY <= 1'b0;
                    end
                end
                W_COMMIT: begin
                    wr_state     <= W_RESP;
                    S_AXI_BVALID <= 1'b1;
                    S_AXI_BRESP  <= aw_oor ? RESP_SLVERR : RESP_OKAY;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wr_state      <= W_IDLE;
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: latch data on the AR handshake, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rd_state      <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state      <= R_DATA;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= ar_oor_c ? '0 : bank_rd;
                        S_AXI_RRESP   <= ar_oor_c ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rd_state      <= R_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
